// File: rtl/pipe_ctrl.sv
// Control and hazard unit for the 3-stage (IF/EX/WB) RV32I core: EX/WB instruction
// registers, reset fill / redirect flush / stall sequencing, datapath selects and counters.
module pipe_ctrl #(
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic        branch_taken,
  input  logic        mem_stall,
  output logic        pc_hold,
  output logic [1:0]  jump_judge,
  output logic        reg1_judge,
  output logic [1:0]  reg2_judge,
  output logic        store_fwd,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic [31:0] ex_inst,
  output logic [31:0] wb_inst,
  output logic        ex_valid,
  output logic        wb_valid,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] FLUSH_LOAD = FLUSH_CYCLES[1:0];

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [1:0] state;
  logic [1:0] flush_cnt;

  logic [6:0] ex_op;
  logic [6:0] wb_op;
  logic [4:0] wb_rd;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic       ex_jump;
  logic       ex_branch;
  logic       redirect;
  logic       fwd_rs1;
  logic       fwd_rs2;
  logic       reads_rs1;

  assign ex_op  = ex_inst[6:0];
  assign wb_op  = wb_inst[6:0];
  assign wb_rd  = wb_inst[11:7];
  assign ex_rs1 = ex_inst[19:15];
  assign ex_rs2 = ex_inst[24:20];

  // mem_stall is a plain freeze, not a handshake: while high, nothing in this block
  // advances except cycle_cnt, and every decoded output tracks the frozen stages.
  assign pc_hold   = mem_stall;
  assign fsm_state = state;

  assign ex_jump   = ex_valid && (ex_op == OP_JAL || ex_op == OP_JALR);
  assign ex_branch = ex_valid && (ex_op == OP_BR);
  assign redirect  = ex_jump || (ex_branch && branch_taken);

  always_comb begin
    jump_judge = 2'b00;
    if (ex_jump) jump_judge = 2'b10;
    else if (ex_branch && branch_taken) jump_judge = 2'b11;
  end

  always_comb begin
    wb_sel = 2'b00;
    if (wb_valid) begin
      case (wb_op)
        OP_R, OP_I, OP_LUI, OP_AUIPC: wb_sel = 2'b01;
        OP_LOAD:                      wb_sel = 2'b10;
        OP_JAL, OP_JALR:              wb_sel = 2'b11;
        default:                      wb_sel = 2'b00;
      endcase
    end
  end

  assign reg_we  = (wb_sel != 2'b00) && (wb_rd != 5'd0);
  assign fwd_rs1 = wb_valid && reg_we && (wb_rd != 5'd0) && (wb_rd == ex_rs1);
  assign fwd_rs2 = wb_valid && reg_we && (wb_rd != 5'd0) && (wb_rd == ex_rs2);

  always_comb begin
    reads_rs1 = 1'b0;
    case (ex_op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR: reads_rs1 = 1'b1;
      default:                                       reads_rs1 = 1'b0;
    endcase
  end

  assign reg1_judge = ex_valid && reads_rs1 && fwd_rs1;
  assign store_fwd  = ex_valid && (ex_op == OP_STORE) && fwd_rs2;

  // Immediate-operand instructions take the imm path regardless of any hazard on rs2.
  always_comb begin
    reg2_judge = 2'b00;
    if (ex_valid) begin
      case (ex_op)
        OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: reg2_judge = 2'b10;
        OP_R, OP_BR: reg2_judge = fwd_rs2 ? 2'b01 : 2'b00;
        default:     reg2_judge = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      flush_cnt   <= 2'd0;
      ex_inst     <= NOP_INST;
      wb_inst     <= NOP_INST;
      ex_valid    <= 1'b0;
      wb_valid    <= 1'b0;
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!mem_stall) begin
        if (wb_valid) instret_cnt <= instret_cnt + 32'd1;
        wb_inst  <= ex_inst;
        wb_valid <= ex_valid;
        case (state)
          S_RUN: begin
            if (redirect) begin
              ex_inst  <= NOP_INST;
              ex_valid <= 1'b0;
              if (FLUSH_LOAD != 2'd0) begin
                state     <= S_FLUSH;
                flush_cnt <= FLUSH_LOAD;
              end
            end else begin
              ex_inst  <= if_inst;
              ex_valid <= 1'b1;
            end
          end
          S_FLUSH: begin
            ex_inst   <= NOP_INST;
            ex_valid  <= 1'b0;
            flush_cnt <= flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) state <= S_RUN;
          end
          default: begin
            // Fill slot: the synchronous IMEM has not produced a word yet.
            ex_inst  <= NOP_INST;
            ex_valid <= 1'b0;
            state    <= S_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan steps followed by random instruction streams,
// all outputs compared every cycle against a behavioural model of the pipeline.
module tb_pipe_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          FLUSH = 1;
  localparam logic [1:0]  ST_FILL  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_FLUSH = 2'd2;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] I_ADDI_X0 = 32'h0050_0013;
  localparam logic [31:0] I_ADD     = 32'h0010_8133;
  localparam logic [31:0] I_BEQ     = 32'h0000_0463;
  localparam logic [31:0] I_JAL     = 32'h0080_00EF;
  localparam logic [31:0] I_SW      = 32'h0011_2023;

  typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUI, C_UNK} cls_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] if_inst = NOP;
  logic        branch_taken = 1'b0;
  logic        mem_stall = 1'b0;
  logic        pc_hold, reg1_judge, store_fwd, reg_we, ex_valid, wb_valid;
  logic [1:0]  jump_judge, reg2_judge, wb_sel, fsm_state;
  logic [31:0] ex_inst, wb_inst, cycle_cnt, instret_cnt;

  pipe_ctrl #(.NOP_INST(NOP), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .branch_taken(branch_taken),
    .mem_stall(mem_stall), .pc_hold(pc_hold), .jump_judge(jump_judge),
    .reg1_judge(reg1_judge), .reg2_judge(reg2_judge), .store_fwd(store_fwd),
    .wb_sel(wb_sel), .reg_we(reg_we), .ex_inst(ex_inst), .wb_inst(wb_inst),
    .ex_valid(ex_valid), .wb_valid(wb_valid), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt), .fsm_state(fsm_state)
  );

  int checks = 0;
  int failures = 0;

  // behavioural model: stage contents, pending squash slots, counters
  logic [31:0] m_ex = NOP, m_wb = NOP;
  logic        m_exv = 1'b0, m_wbv = 1'b0;
  logic [31:0] m_cyc = 0, m_ret = 0;
  bit          m_fill = 1'b1;
  int          m_squash = 0;
  logic [31:0] exp_q[$];

  function automatic cls_t cls(input logic [31:0] i);
    case (i[6:0])
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6f: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUI;
      default: return C_UNK;
    endcase
  endfunction

  function automatic logic [1:0] exp_wb_sel();
    if (!m_wbv) return 2'b00;
    case (cls(m_wb))
      C_R, C_I, C_LUI, C_AUI: return 2'b01;
      C_LD: return 2'b10;
      C_JAL, C_JALR: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit exp_we();
    return (exp_wb_sel() != 2'b00) && (m_wb[11:7] != 5'd0);
  endfunction

  function automatic bit hazard(input logic [4:0] rs);
    return m_wbv && exp_we() && (m_wb[11:7] != 5'd0) && (m_wb[11:7] == rs);
  endfunction

  function automatic logic [1:0] exp_jj();
    cls_t c = cls(m_ex);
    if (!m_exv) return 2'b00;
    if (c == C_JAL || c == C_JALR) return 2'b10;
    if (c == C_BR && branch_taken) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit exp_r1();
    cls_t c = cls(m_ex);
    bit reads = (c == C_R || c == C_I || c == C_LD || c == C_ST || c == C_BR || c == C_JALR);
    return m_exv && reads && hazard(m_ex[19:15]);
  endfunction

  function automatic logic [1:0] exp_r2();
    cls_t c = cls(m_ex);
    if (!m_exv) return 2'b00;
    if (c == C_I || c == C_LD || c == C_ST || c == C_JALR || c == C_LUI || c == C_AUI || c == C_JAL)
      return 2'b10;
    if ((c == C_R || c == C_BR) && hazard(m_ex[24:20])) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_fill) return ST_FILL;
    if (m_squash > 0) return ST_FLUSH;
    return ST_RUN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every output against the model, plus retirement order via exp_q
  task automatic compare_all();
    chk("pc_hold",     32'(pc_hold),     32'(mem_stall));
    chk("jump_judge",  32'(jump_judge),  32'(exp_jj()));
    chk("reg1_judge",  32'(reg1_judge),  32'(exp_r1()));
    chk("reg2_judge",  32'(reg2_judge),  32'(exp_r2()));
    chk("store_fwd",   32'(store_fwd),   32'(m_exv && cls(m_ex) == C_ST && hazard(m_ex[24:20])));
    chk("wb_sel",      32'(wb_sel),      32'(exp_wb_sel()));
    chk("reg_we",      32'(reg_we),      32'(exp_we()));
    chk("ex_inst",     ex_inst,          m_ex);
    chk("wb_inst",     wb_inst,          m_wb);
    chk("ex_valid",    32'(ex_valid),    32'(m_exv));
    chk("wb_valid",    32'(wb_valid),    32'(m_wbv));
    chk("cycle_cnt",   cycle_cnt,        m_cyc);
    chk("instret_cnt", instret_cnt,      m_ret);
    chk("fsm_state",   32'(fsm_state),   32'(exp_state()));
    if (!rst && !mem_stall && m_wbv) begin
      if (exp_q.size() == 0) chk("retire_queue_empty", 32'd1, 32'd0);
      else chk("retire_order", wb_inst, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] inst, input logic taken, input logic stall,
                       input logic r);
    @(negedge clk);
    if_inst = inst;
    branch_taken = taken;
    mem_stall = stall;
    rst = r;
    #1;
    compare_all();
  endtask

  task automatic tick();
    bit redirect;
    cls_t c;
    @(posedge clk);
    if (rst) begin
      m_ex = NOP; m_wb = NOP; m_exv = 1'b0; m_wbv = 1'b0;
      m_cyc = 0; m_ret = 0; m_fill = 1'b1; m_squash = 0;
      exp_q.delete();
    end else begin
      m_cyc = m_cyc + 1;
      if (!mem_stall) begin
        c = cls(m_ex);
        redirect = m_exv && (c == C_JAL || c == C_JALR || (c == C_BR && branch_taken));
        if (m_wbv) m_ret = m_ret + 1;
        m_wb = m_ex;
        m_wbv = m_exv;
        if (m_fill || redirect || m_squash > 0) begin
          m_ex = NOP;
          m_exv = 1'b0;
          if (m_fill) m_fill = 1'b0;
          else if (redirect) m_squash = FLUSH;
          else m_squash--;
        end else begin
          m_ex = if_inst;
          m_exv = 1'b1;
          exp_q.push_back(if_inst);
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
    logic [31:0] r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    // reset for two cycles; the first edge only seeds the DUT from X
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();

    // reset state, fill slot, first instruction through WB
    drive(I_ADDI_X1, 1'b0, 1'b0, 1'b0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_FILL));
    tick();
    drive(I_ADDI_X1, 1'b0, 1'b0, 1'b0);
    chk("fill_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    drive(I_ADD, 1'b0, 1'b0, 1'b0);
    chk("run_ex_valid", 32'(ex_valid), 32'd1);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("addi_wb_sel", 32'(wb_sel), 32'd1);
    chk("addi_reg_we", 32'(reg_we), 32'd1);
    chk("add_fwd_a", 32'(reg1_judge), 32'd1);
    chk("add_fwd_b", 32'(reg2_judge), 32'd1);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("instret_first", instret_cnt, 32'd1);
    tick();

    // writer targets x0: no forwarding
    drive(I_ADDI_X0, 1'b0, 1'b0, 1'b0); tick();
    drive(I_ADD, 1'b0, 1'b0, 1'b0); tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("x0_fwd_a", 32'(reg1_judge), 32'd0);
    chk("x0_fwd_b", 32'(reg2_judge), 32'd0);
    tick();

    // taken branch: one redirect cycle then two bubbles
    drive(I_BEQ, 1'b0, 1'b0, 1'b0); tick();
    drive(NOP, 1'b1, 1'b0, 1'b0);
    chk("beq_taken_jj", 32'(jump_judge), 32'd3);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("beq_bubble1", 32'(ex_valid), 32'd0);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("beq_bubble2", 32'(ex_valid), 32'd0);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("beq_resume", 32'(ex_valid), 32'd1);
    tick();

    // untaken branch: no bubbles
    drive(I_BEQ, 1'b0, 1'b0, 1'b0); tick();
    drive(I_ADDI_X1, 1'b0, 1'b0, 1'b0);
    chk("beq_nt_jj", 32'(jump_judge), 32'd0);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("beq_nt_ex", ex_inst, I_ADDI_X1);
    tick();

    // jal frozen by a 3-cycle stall, redirect taken on release
    drive(I_JAL, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(NOP, 1'b0, 1'b1, 1'b0);
      chk("jal_stall_jj", 32'(jump_judge), 32'd2);
      chk("jal_stall_hold", 32'(pc_hold), 32'd1);
      chk("jal_stall_ex", ex_inst, I_JAL);
      tick();
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("jal_release_jj", 32'(jump_judge), 32'd2);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("jal_wb_sel", 32'(wb_sel), 32'd3);
    chk("jal_bubble", 32'(ex_valid), 32'd0);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0); tick();

    // store with forwarded data
    drive(I_ADDI_X1, 1'b0, 1'b0, 1'b0); tick();
    drive(I_SW, 1'b0, 1'b0, 1'b0); tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("sw_reg2", 32'(reg2_judge), 32'd2);
    chk("sw_store_fwd", 32'(store_fwd), 32'd1);
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("sw_wb_we", 32'(reg_we), 32'd0);
    tick();

    // reset wins over stall while flushing
    drive(I_JAL, 1'b0, 1'b0, 1'b0); tick();
    drive(NOP, 1'b0, 1'b0, 1'b0); tick();
    drive(NOP, 1'b0, 1'b1, 1'b1);
    chk("flush_state", 32'(fsm_state), 32'(ST_FLUSH));
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    chk("rst_flush_state", 32'(fsm_state), 32'(ST_FILL));
    chk("rst_flush_wbv", 32'(wb_valid), 32'd0);
    chk("rst_flush_cyc", cycle_cnt, 32'd0);
    chk("rst_flush_ret", instret_cnt, 32'd0);
    tick();

    // random streams against the model
    for (int n = 0; n < 3000; n++) begin
      drive(rand_inst(), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 199) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
